// File: rtl/sd_seq_gen.sv
// sd_seq_gen: srdy/drdy traffic producer emitting {tag_val, seq} words with pattern-based throttling.
// Optional gap injection is compiled in with `define SDLIB_SEQ_GEN_ERR_INJ_EN.
module sd_seq_gen #(
    parameter int unsigned width   = 8,
    parameter int unsigned tag_sz  = 1,
    parameter int unsigned tag_val = 0,
    parameter int unsigned pat_dep = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [pat_dep-1:0] srdy_pat,
    input  logic [15:0]        max_xfers,
    output logic               p_srdy,
    input  logic               p_drdy,
    output logic [width-1:0]   p_data,
    output logic [15:0]        xfer_cnt,
`ifdef SDLIB_SEQ_GEN_ERR_INJ_EN
    input  logic               err_inj,
    output logic [7:0]         inj_cnt,
`endif
    output logic               done
);

    localparam int unsigned COUNT_SZ = width - tag_sz;
    localparam int unsigned PPOS_W   = (pat_dep > 1) ? $clog2(pat_dep) : 1;
    localparam int unsigned CNT_W    = 16;

    localparam logic [tag_sz-1:0] TAG      = tag_sz'(tag_val);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic                p_srdy_q, p_srdy_d;
    logic [COUNT_SZ-1:0] seq_q,    seq_d;
    logic [PPOS_W-1:0]   ppos_q,   ppos_d;
    logic [CNT_W-1:0]    xfer_cnt_q, xfer_cnt_d;
    logic                done_q,   done_d;

    logic                xfer;
    logic                decide;
    logic                lim_next;
    logic [CNT_W:0]      cnt_plus;
    logic [COUNT_SZ-1:0] seq_step;

`ifdef SDLIB_SEQ_GEN_ERR_INJ_EN
    logic       inj_pend_q, inj_pend_d;
    logic [7:0] inj_cnt_q,  inj_cnt_d;
    logic       inj_now;
`endif

    assign xfer   = p_srdy_q & p_drdy;
    // A new offer may only be decided once the current one is gone.
    assign decide = xfer | ~p_srdy_q;

    // Limit check uses the count as it will be after this edge; 17 bits avoid saturation aliasing.
    assign cnt_plus = {1'b0, xfer_cnt_q} + (CNT_W + 1)'(xfer);
    assign lim_next = (max_xfers != 16'd0) && (cnt_plus >= {1'b0, max_xfers});

`ifdef SDLIB_SEQ_GEN_ERR_INJ_EN
    assign inj_now  = xfer & inj_pend_q;
    assign seq_step = inj_now ? COUNT_SZ'(2) : COUNT_SZ'(1);
`else
    assign seq_step = COUNT_SZ'(1);
`endif

    // Next-state computation.
    always_comb begin
        p_srdy_d   = p_srdy_q;
        seq_d      = seq_q;
        ppos_d     = ppos_q;
        xfer_cnt_d = xfer_cnt_q;
        done_d     = lim_next;

        if (xfer) begin
            seq_d = seq_q + seq_step;
            if (xfer_cnt_q != CNT_MAX) begin
                xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
            end
        end

        if (decide) begin
            ppos_d   = ppos_q + PPOS_W'(1);
            p_srdy_d = enable & srdy_pat[ppos_q] & ~lim_next;
        end
    end

`ifdef SDLIB_SEQ_GEN_ERR_INJ_EN
    // Sticky injection request, consumed by the next handshake.
    always_comb begin
        inj_pend_d = inj_pend_q;
        inj_cnt_d  = inj_cnt_q;
        if (inj_now) begin
            inj_pend_d = 1'b0;
            if (inj_cnt_q != 8'hFF) begin
                inj_cnt_d = inj_cnt_q + 8'd1;
            end
        end
        if (err_inj) begin
            inj_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inj_pend_q <= 1'b0;
            inj_cnt_q  <= 8'd0;
        end else begin
            inj_pend_q <= inj_pend_d;
            inj_cnt_q  <= inj_cnt_d;
        end
    end

    assign inj_cnt = inj_cnt_q;
`endif

    // State registers; synchronous reset wins over everything, including a pending offer.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_srdy_q   <= 1'b0;
            seq_q      <= '0;
            ppos_q     <= '0;
            xfer_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            p_srdy_q   <= p_srdy_d;
            seq_q      <= seq_d;
            ppos_q     <= ppos_d;
            xfer_cnt_q <= xfer_cnt_d;
            done_q     <= done_d;
        end
    end

    assign p_srdy   = p_srdy_q;
    assign p_data   = {TAG, seq_q};
    assign xfer_cnt = xfer_cnt_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sd_seq_gen.sv
// Directed testbench for sd_seq_gen (width 8, tag_sz 1, tag_val 1, pat_dep 8).
module tb_sd_seq_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  srdy_pat;
    logic [15:0] max_xfers;
    logic        p_srdy;
    logic        p_drdy;
    logic [7:0]  p_data;
    logic [15:0] xfer_cnt;
    logic        done;
`ifdef SDLIB_SEQ_GEN_ERR_INJ_EN
    logic        err_inj;
    logic [7:0]  inj_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    sd_seq_gen #(
        .width   (8),
        .tag_sz  (1),
        .tag_val (1),
        .pat_dep (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .srdy_pat  (srdy_pat),
        .max_xfers (max_xfers),
        .p_srdy    (p_srdy),
        .p_drdy    (p_drdy),
        .p_data    (p_data),
        .xfer_cnt  (xfer_cnt),
`ifdef SDLIB_SEQ_GEN_ERR_INJ_EN
        .err_inj   (err_inj),
        .inj_cnt   (inj_cnt),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic es, input logic [7:0] ed,
                           input logic [15:0] ec, input logic edn);
        chk({tag, ".p_srdy"},   32'(p_srdy),   32'(es));
        chk({tag, ".p_data"},   32'(p_data),   32'(ed));
        chk({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(ec));
        chk({tag, ".done"},     32'(done),     32'(edn));
    endtask

    int          lim_drdy [1:14];
    int          lim_cnt  [1:14];
    logic [15:0] c16;

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        srdy_pat  = 8'hFF;
        max_xfers = 16'd0;
        p_drdy    = 1'b0;
`ifdef SDLIB_SEQ_GEN_ERR_INJ_EN
        err_inj   = 1'b0;
`endif
        step();
        step();
        chk_all("reset", 1'b0, 8'h80, 16'd0, 1'b0);

        // Back-to-back streaming with wrap of the 7-bit sequence.
        reset  = 1'b0;
        enable = 1'b1;
        p_drdy = 1'b1;
        step();
        chk_all("first_offer", 1'b1, 8'h80, 16'd0, 1'b0);
        for (int k = 1; k <= 130; k++) begin
            step();
            c16 = 16'(k);
            chk_all("stream", 1'b1, {1'b1, c16[6:0]}, c16, 1'b0);
        end

        // Throttle pattern: ppos is 3 here, so slots alternate 0,1,0,1...
        srdy_pat = 8'b0101_0101;
        step();
        chk_all("pat_e1", 1'b0, 8'h83, 16'd131, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            step();
            c16 = 16'(131 + (k - 1) / 2);
            chk_all("pat", (k % 2) == 0, {1'b1, c16[6:0]}, c16, 1'b0);
        end

        // Stall with enable dropped mid-stall: offer held, then no new offer.
        p_drdy = 1'b0;
        step();
        chk_all("stall_offer", 1'b1, 8'h87, 16'd135, 1'b0);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all("stall_hold", 1'b1, 8'h87, 16'd135, 1'b0);
        end
        p_drdy = 1'b1;
        step();
        chk_all("stall_accept", 1'b0, 8'h88, 16'd136, 1'b0);
        step();
        chk_all("stall_idle", 1'b0, 8'h88, 16'd136, 1'b0);

        // Transfer limit of 10 with an irregular drdy pattern.
        reset = 1'b1;
        step();
        chk_all("reset2", 1'b0, 8'h80, 16'd0, 1'b0);
        reset     = 1'b0;
        enable    = 1'b1;
        srdy_pat  = 8'hFF;
        max_xfers = 16'd10;
        lim_drdy  = '{0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        lim_cnt   = '{0, 1, 2, 2, 3, 4, 5, 5, 6, 7, 8, 9, 10, 10};
        for (int k = 1; k <= 14; k++) begin
            p_drdy = lim_drdy[k] != 0;
            step();
            c16 = 16'(lim_cnt[k]);
            chk_all("limit", k <= 12, {1'b1, c16[6:0]}, c16, k >= 13);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("limit_after", 1'b0, 8'h8A, 16'd10, 1'b1);
        end

        // Reset during a stalled offer at seq 0x23.
        max_xfers = 16'd0;
        p_drdy    = 1'b1;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            step();
        end
        chk_all("pre_stall", 1'b1, 8'hA3, 16'd35, 1'b0);
        p_drdy = 1'b0;
        step();
        chk_all("stall_23", 1'b1, 8'hA3, 16'd35, 1'b0);
        reset = 1'b1;
        step();
        chk_all("mid_reset", 1'b0, 8'h80, 16'd0, 1'b0);
        reset  = 1'b0;
        p_drdy = 1'b1;
        step();
        chk_all("restart", 1'b1, 8'h80, 16'd0, 1'b0);
        step();
        chk_all("restart2", 1'b1, 8'h81, 16'd1, 1'b0);

`ifdef SDLIB_SEQ_GEN_ERR_INJ_EN
        // Injected gap: word after the next handshake skips one value.
        err_inj = 1'b1;
        step();
        err_inj = 1'b0;
        chk_all("inj_arm", 1'b1, 8'h82, 16'd2, 1'b0);
        chk("inj_cnt0", 32'(inj_cnt), 32'd0);
        step();
        chk_all("inj_gap", 1'b1, 8'h84, 16'd3, 1'b0);
        chk("inj_cnt1", 32'(inj_cnt), 32'd1);
        step();
        chk_all("inj_after", 1'b1, 8'h85, 16'd4, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sd_seq_gen.md
Name: sd_seq_gen

Overview:
Srdy/drdy traffic producer. It emits an incrementing, tagged data sequence with programmable srdy throttling. It is the producer-side bench companion to the team's sequence checker: it drives the consumer port of a DUT and supplies the stimulus that the checker validates. It is synthesizable, so it can also run as a built-in traffic source in FPGA bring-up.

Parameters:
- width, 8, total p_data width.
- tag_sz, 1, width of the constant tag field in the data MSBs (1 .. width-1).
- tag_val, 0, tag value, truncated to tag_sz bits.
- pat_dep, 8, depth of the srdy throttle pattern (power of 2, >= 2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  allows new offers when high.
- srdy_pat  input  pat_dep  throttle pattern. Bit i=1 means an offer is allowed in pattern slot i.
- max_xfers  input  16  transfer limit. 0 = unlimited. Sampled every cycle; must be held stable while enable=1.
- p_srdy  output  1  producer valid.
- p_drdy  input  1  consumer ready.
- p_data  output  width  {tag_val, seq}.
- xfer_cnt  output  16  completed transfers since reset. Saturates at 16'hFFFF.
- done  output  1  limit reached.

Behaviour:
- count_sz = width - tag_sz. p_data = {tag_val[tag_sz-1:0], seq[count_sz-1:0]}. All outputs are registered.
- Reset (sync, priority over everything): p_srdy=0, seq=0, ppos=0, xfer_cnt=0, done=0. p_data therefore reads {tag_val, 0}.
- Reset asserted mid-offer: p_srdy drops at that edge with no handshake. seq restarts at 0.
- Per cycle, xfer = p_srdy & p_drdy.
- On xfer:
  - seq <= seq+1, wrapping modulo 2^count_sz (all-ones -> 0, with no gap).
  - xfer_cnt <= xfer_cnt+1, saturating.
- Offer decision happens only when (xfer | !p_srdy):
  - ppos <= (ppos+1) mod pat_dep.
  - p_srdy <= enable & srdy_pat[ppos] & !lim_next.
  - lim_next = (max_xfers != 0) & ((xfer_cnt + xfer) >= max_xfers).
- Otherwise (p_srdy=1 and p_drdy=0):
  - Hold p_srdy and p_data unchanged.
  - ppos does not advance.
  - No retraction, even if enable falls or srdy_pat changes.
- Back-to-back: with srdy_pat all ones, enable=1 and p_drdy=1, one transfer per cycle and p_srdy stays high.
- Latency: first edge with reset=0, enable=1, srdy_pat[0]=1 sets p_srdy=1. The first word is seq 0.
- done <= lim_next, evaluated every cycle (it does not wait for an offer decision).
  - Once done=1, no further offers are made until reset or max_xfers is raised.
  - done is never set when max_xfers=0.
  - The last transfer and done assertion coincide: done rises at the edge where the final xfer completes.
- enable low: any pending offer completes normally; no new offer is made. ppos keeps advancing while p_srdy=0.

Optional Feature:
Macro SDLIB_SEQ_GEN_ERR_INJ_EN.
- Defined:
  - Adds input err_inj (1 bit).
  - err_inj sampled high sets a sticky inj_pend flag.
  - At the next xfer with inj_pend=1, seq advances by 2 instead of 1 (the following word skips one value) and inj_pend clears.
  - Output inj_cnt (8 bits, saturating) counts injected gaps; it resets to 0.
- Not defined: the err_inj and inj_cnt ports do not exist and seq always increments by 1.

Test Plan:
- Reset release, enable=1, srdy_pat=8'hFF, p_drdy=1, max_xfers=0, width=8, tag_sz=1, tag_val=1 -> p_srdy high 1 cycle after reset; p_data 8'h80, 8'h81, 8'h82 ... on consecutive cycles; wraps 8'hFF -> 8'h80; checker reports 0 errors.
- srdy_pat=8'b01010101, p_drdy=1 -> exactly 4 transfers per 8-cycle window; data still contiguous.
- p_drdy held low 5 cycles while p_srdy=1, enable dropped during the stall -> p_srdy and p_data stable all 5 cycles; word accepted when p_drdy rises; no new offer afterwards.
- max_xfers=10, random p_drdy -> exactly 10 transfers (seq 0..9); done=1 at the same edge xfer_cnt becomes 10; p_srdy=0 thereafter; xfer_cnt stays 10.
- Reset asserted for 1 cycle during a stalled offer at seq 0x23 -> p_srdy=0, xfer_cnt=0 next cycle; next word is seq 0.
- (SDLIB_SEQ_GEN_ERR_INJ_EN) err_inj pulse before the transfer of seq 5 -> sequence 4, 5, 7; inj_cnt=1; checker flags exactly 1 miscompare.
